// File: rtl/simd_lane_engine_if.sv
// Bundled instruction, operand-beat and result signals of simd_lane_engine.
// master drives instructions and operand beats; slave is the engine.
interface simd_lane_engine_if #(
  parameter int LANES   = 2,
  parameter int LANE_W  = 32,
  parameter int BURST_W = 6
);
  logic                      valid_instruction;
  logic [2:0]                instruction;
  logic [BURST_W-1:0]        data_size;
  logic                      valid_data;
  logic [LANES*LANE_W-1:0]   mc_data_in_opa;
  logic [LANES*LANE_W-1:0]   mc_data_in_opb;
  logic                      in_ready;
  logic                      out_valid;
  logic [LANES*LANE_W-1:0]   out_lane;
  logic [LANES*LANE_W-1:0]   out_extra;
  logic                      busy;
  logic                      done;

  modport master (
    output valid_instruction, instruction, data_size, valid_data,
           mc_data_in_opa, mc_data_in_opb,
    input  in_ready, out_valid, out_lane, out_extra, busy, done
  );

  modport slave (
    input  valid_instruction, instruction, data_size, valid_data,
           mc_data_in_opa, mc_data_in_opb,
    output in_ready, out_valid, out_lane, out_extra, busy, done
  );
endinterface

// File: rtl/simd_lane_engine.sv
// SIMD burst engine: one latched opcode over LANES x LANE_W lanes; result two edges after beat accept.
// in_ready only in RUN, outputs never stall; define SIMD_SAT_EN to clamp ADD/SUB lane results.
module simd_lane_engine #(
  parameter int LANES   = 2,
  parameter int LANE_W  = 32,
  parameter int BURST_W = 6
) (
  input logic               clk,
  input logic               reset_n,
  simd_lane_engine_if.slave bus
);
  localparam int BW = LANES * LANE_W;
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_MUL = 3'd2, OP_AND = 3'd3,
                         OP_OR  = 3'd4, OP_XOR = 3'd5, OP_MAC = 3'd6, OP_PASS = 3'd7;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                               state;
  logic [2:0]                           op_q;
  logic [BURST_W-1:0]                   size_q, cnt;
  logic                                 s1_vld, s1_last, s2_vld, s2_last;
  logic [BW-1:0]                        s1_a, s1_b;
  logic [LANES-1:0][2*LANE_W-1:0]       s2_res, res_c, acc, acc_c;
  logic [BW-1:0]                        fin_lo, fin_hi;
  logic                                 out_valid_q, done_q;
  logic [BW-1:0]                        out_lane_q, out_extra_q;
  logic                                 accept, last_beat;

  assign accept    = (state == RUN) && bus.valid_data;
  assign last_beat = accept && (cnt == size_q - BURST_W'(1));

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [LANE_W-1:0] a, b, lo, hi;
    logic [LANE_W:0]   sum;
    logic              borrow;

    assign a      = s1_a[g*LANE_W +: LANE_W];
    assign b      = s1_b[g*LANE_W +: LANE_W];
    assign sum    = {1'b0, a} + {1'b0, b};
    assign borrow = a < b;

    always_comb begin
      lo = '0;
      hi = '0;
      case (op_q)
        OP_ADD: begin
`ifdef SIMD_SAT_EN
          lo = sum[LANE_W] ? '1 : sum[LANE_W-1:0];
`else
          lo = sum[LANE_W-1:0];
`endif
          hi = LANE_W'(sum[LANE_W]);
        end
        OP_SUB: begin
`ifdef SIMD_SAT_EN
          lo = borrow ? '0 : a - b;
`else
          lo = a - b;
`endif
          hi = LANE_W'(borrow);
        end
        // MAC only forms the product here; accumulation happens in the output stage
        OP_MUL, OP_MAC: {hi, lo} = {{LANE_W{1'b0}}, a} * {{LANE_W{1'b0}}, b};
        OP_AND:  lo = a & b;
        OP_OR:   lo = a | b;
        OP_XOR:  lo = a ^ b;
        OP_PASS: begin
          lo = a;
          hi = b;
        end
        default: lo = '0;
      endcase
    end

    assign res_c[g] = {hi, lo};
    assign acc_c[g] = acc[g] + s2_res[g];
    assign fin_lo[g*LANE_W +: LANE_W] = (op_q == OP_MAC) ? acc_c[g][LANE_W-1:0]
                                                         : s2_res[g][LANE_W-1:0];
    assign fin_hi[g*LANE_W +: LANE_W] = (op_q == OP_MAC) ? acc_c[g][2*LANE_W-1:LANE_W]
                                                         : s2_res[g][2*LANE_W-1:LANE_W];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      op_q        <= '0;
      size_q      <= '0;
      cnt         <= '0;
      s1_vld      <= 1'b0;
      s1_last     <= 1'b0;
      s1_a        <= '0;
      s1_b        <= '0;
      s2_vld      <= 1'b0;
      s2_last     <= 1'b0;
      s2_res      <= '0;
      acc         <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      out_lane_q  <= '0;
      out_extra_q <= '0;
    end else begin
      done_q      <= 1'b0;
      out_valid_q <= s2_vld;
      s1_vld      <= accept;
      s1_last     <= last_beat;
      s2_vld      <= s1_vld;
      s2_last     <= s1_vld && s1_last;
      if (accept) begin
        s1_a <= bus.mc_data_in_opa;
        s1_b <= bus.mc_data_in_opb;
      end
      if (s1_vld) s2_res <= res_c;
      if (s2_vld) begin
        out_lane_q  <= fin_lo;
        out_extra_q <= fin_hi;
        done_q      <= s2_last;
        if (op_q == OP_MAC) acc <= acc_c;
      end
      case (state)
        IDLE: if (bus.valid_instruction) begin
          if (bus.data_size != '0) begin
            state  <= RUN;
            op_q   <= bus.instruction;
            size_q <= bus.data_size;
            cnt    <= '0;
            acc    <= '0;
          end else begin
            done_q <= 1'b1;
          end
        end
        RUN: if (accept) begin
          cnt <= cnt + BURST_W'(1);
          if (last_beat) state <= DRAIN;
        end
        // done_q marks the final result on the outputs this cycle
        DRAIN: if (done_q) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == RUN);
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.done      = done_q;
  assign bus.out_lane  = out_lane_q;
  assign bus.out_extra = out_extra_q;
endmodule

// File: tb/tb_simd_lane_engine.sv
// Directed and randomized bursts for simd_lane_engine (LANES=2, LANE_W=32) against an arithmetic lane model.
`timescale 1ns/1ps
module tb_simd_lane_engine;
  localparam int LANES = 2, LANE_W = 32, BURST_W = 6;

  logic clk = 1'b0;
  logic reset_n;
  int   tests = 0;
  int   fails = 0;

  simd_lane_engine_if #(.LANES(LANES), .LANE_W(LANE_W), .BURST_W(BURST_W)) bus ();
  simd_lane_engine #(.LANES(LANES), .LANE_W(LANE_W), .BURST_W(BURST_W)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [63:0] got_lane[$], got_extra[$], exp_lane[$], exp_extra[$];
  bit          got_done[$], got_busy[$];
  int          done_cnt = 0;
  bit          prev_done = 1'b0;
  bit          busy_after_done = 1'b1;
  logic [63:0] ba[64], bb[64];

  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      got_lane.push_back(bus.out_lane);
      got_extra.push_back(bus.out_extra);
      got_done.push_back(bus.done);
      got_busy.push_back(bus.busy);
    end
    if (bus.done === 1'b1) done_cnt++;
    if (prev_done) busy_after_done = bus.busy;
    prev_done = bus.done;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] at_lane(input int i);
    return (i < got_lane.size()) ? got_lane[i] : 64'hx;
  endfunction
  function automatic logic [63:0] at_extra(input int i);
    return (i < got_extra.size()) ? got_extra[i] : 64'hx;
  endfunction

  // Returns {extra, out} for one lane; acc_in is that lane's running MAC total
  function automatic logic [63:0] lane_ref(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [63:0] acc_in);
    logic [63:0] wa, wb, r;
    wa = {32'd0, a};
    wb = {32'd0, b};
    case (op)
      3'd0: begin
        r = wa + wb;
`ifdef SIMD_SAT_EN
        if (r > 64'h00000000_FFFFFFFF) r = 64'h00000001_FFFFFFFF;
`endif
      end
      3'd1: begin
        if (a < b) begin
          r = {32'd1, a - b};
`ifdef SIMD_SAT_EN
          r = 64'h00000001_00000000;
`endif
        end else begin
          r = {32'd0, a - b};
        end
      end
      3'd2: r = wa * wb;
      3'd3: r = wa & wb;
      3'd4: r = wa | wb;
      3'd5: r = wa ^ wb;
      3'd6: r = acc_in + wa * wb;
      default: r = {b, a};
    endcase
    return r;
  endfunction

  task automatic run_burst(input string tag, input logic [2:0] op, input int n,
                           input bit gaps, input bit inject);
    logic [63:0] acc[2];
    logic [63:0] r, el, ex;
    int base;
    got_lane.delete(); got_extra.delete(); got_done.delete(); got_busy.delete();
    exp_lane.delete(); exp_extra.delete();
    acc[0] = '0;
    acc[1] = '0;
    for (int i = 0; i < n; i++) begin
      for (int l = 0; l < 2; l++) begin
        r = lane_ref(op, ba[i][l*32 +: 32], bb[i][l*32 +: 32], acc[l]);
        if (op == 3'd6) acc[l] = r;
        el[l*32 +: 32] = r[31:0];
        ex[l*32 +: 32] = r[63:32];
      end
      exp_lane.push_back(el);
      exp_extra.push_back(ex);
    end
    base = done_cnt;
    busy_after_done = 1'b1;
    bus.valid_instruction = 1'b1;
    bus.instruction = op;
    bus.data_size = BURST_W'(n);
    @(negedge clk);
    bus.valid_instruction = 1'b0;
    for (int i = 0; i < n; i++) begin
      while (gaps && $urandom_range(0, 2) == 0) @(negedge clk);
      if (inject && i == 1) begin
        bus.valid_instruction = 1'b1;
        bus.instruction = op ^ 3'b101;
        bus.data_size = 6'd9;
      end
      chk($sformatf("%s_in_ready%0d", tag, i), bus.in_ready, 1);
      bus.valid_data = 1'b1;
      bus.mc_data_in_opa = ba[i];
      bus.mc_data_in_opb = bb[i];
      @(negedge clk);
      bus.valid_data = 1'b0;
      bus.valid_instruction = 1'b0;
    end
    for (int t = 0; t < 64; t++) begin
      if (got_lane.size() >= n && !bus.busy) break;
      @(negedge clk);
    end
    @(negedge clk);
    chk({tag, "_count"}, got_lane.size(), n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_lane%0d", tag, i), at_lane(i), exp_lane[i]);
      chk($sformatf("%s_extra%0d", tag, i), at_extra(i), exp_extra[i]);
      if (i < got_done.size())
        chk($sformatf("%s_done%0d", tag, i), got_done[i], (i == n - 1));
    end
    if (got_busy.size() > 0) chk({tag, "_busy_last"}, got_busy[got_busy.size()-1], 1);
    chk({tag, "_done_pulses"}, done_cnt - base, 1);
    chk({tag, "_busy_fall"}, busy_after_done, 0);
  endtask

  initial begin
    int base, nq;
    reset_n = 1'b0;
    bus.valid_instruction = 1'b0;
    bus.instruction = '0;
    bus.data_size = '0;
    bus.valid_data = 1'b0;
    bus.mc_data_in_opa = '0;
    bus.mc_data_in_opb = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_lane", bus.out_lane, 0);
    chk("rst_out_extra", bus.out_extra, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single ADD beat, cycle-by-cycle latency
    bus.valid_instruction = 1'b1;
    bus.instruction = 3'd0;
    bus.data_size = 6'd1;
    @(negedge clk);
    bus.valid_instruction = 1'b0;
    chk("t1_in_ready", bus.in_ready, 1);
    chk("t1_busy_run", bus.busy, 1);
    bus.valid_data = 1'b1;
    bus.mc_data_in_opa = 64'h11111111_22222222;
    bus.mc_data_in_opb = 64'h11111111_22222222;
    @(negedge clk);
    bus.valid_data = 1'b0;
    chk("t1_lat0", bus.out_valid, 0);
    chk("t1_drain_in_ready", bus.in_ready, 0);
    @(negedge clk);
    chk("t1_lat1", bus.out_valid, 0);
    @(negedge clk);
    chk("t1_out_valid", bus.out_valid, 1);
    chk("t1_out_lane", bus.out_lane, 64'h22222222_44444444);
    chk("t1_out_extra", bus.out_extra, 0);
    chk("t1_done", bus.done, 1);
    chk("t1_busy", bus.busy, 1);
    @(negedge clk);
    chk("t1_valid_drop", bus.out_valid, 0);
    chk("t1_done_drop", bus.done, 0);
    chk("t1_busy_drop", bus.busy, 0);
    chk("t1_hold", bus.out_lane, 64'h22222222_44444444);

    // ADD carry out of lane 0 must not reach lane 1
    ba[0] = 64'h00000000_FFFFFFFF;
    bb[0] = 64'h00000000_00000001;
    run_burst("t2", 3'd0, 1, 1'b0, 1'b0);
`ifdef SIMD_SAT_EN
    chk("t2_const_lane", at_lane(0), 64'h00000000_FFFFFFFF);
`else
    chk("t2_const_lane", at_lane(0), 64'h00000000_00000000);
`endif
    chk("t2_const_extra", at_extra(0), 64'h00000000_00000001);

    ba[0] = 64'h00000003_00010000;
    bb[0] = 64'h00000003_00010000;
    run_burst("t3", 3'd2, 1, 1'b0, 1'b0);
    chk("t3_const_lane", at_lane(0), 64'h00000009_00000000);
    chk("t3_const_extra", at_extra(0), 64'h00000000_00000001);

    ba[0] = {$urandom, 32'd2}; bb[0] = {$urandom, 32'd3};
    ba[1] = {$urandom, 32'd4}; bb[1] = {$urandom, 32'd5};
    ba[2] = {$urandom, 32'd6}; bb[2] = {$urandom, 32'd7};
    run_burst("t4", 3'd6, 3, 1'b1, 1'b0);
    chk("t4_mac0", {32'd0, at_lane(0) & 64'hFFFFFFFF}, 6);
    chk("t4_mac1", {32'd0, at_lane(1) & 64'hFFFFFFFF}, 26);
    chk("t4_mac2", {32'd0, at_lane(2) & 64'hFFFFFFFF}, 68);

    // Zero-length burst
    base = done_cnt;
    nq = got_lane.size();
    bus.valid_instruction = 1'b1;
    bus.instruction = 3'd0;
    bus.data_size = 6'd0;
    @(negedge clk);
    bus.valid_instruction = 1'b0;
    chk("t5_done", bus.done, 1);
    chk("t5_busy", bus.busy, 0);
    chk("t5_no_valid", bus.out_valid, 0);
    @(negedge clk);
    chk("t5_done_drop", bus.done, 0);
    chk("t5_one_pulse", done_cnt - base, 1);
    chk("t5_no_output", got_lane.size(), nq);

    for (int i = 0; i < 4; i++) begin
      ba[i] = {$urandom, $urandom};
      bb[i] = {$urandom, $urandom};
    end
    run_burst("t5_inject", 3'd0, 4, 1'b1, 1'b1);

    // Reset in the middle of a 10-beat burst
    for (int i = 0; i < 10; i++) begin
      ba[i] = {$urandom, $urandom};
      bb[i] = {$urandom, $urandom};
    end
    bus.valid_instruction = 1'b1;
    bus.instruction = 3'd0;
    bus.data_size = 6'd10;
    @(negedge clk);
    bus.valid_instruction = 1'b0;
    bus.valid_data = 1'b1;
    bus.mc_data_in_opa = ba[0];
    bus.mc_data_in_opb = bb[0];
    @(negedge clk);
    bus.mc_data_in_opa = ba[1];
    bus.mc_data_in_opb = bb[1];
    @(negedge clk);
    bus.valid_data = 1'b0;
    base = done_cnt;
    nq = got_lane.size();
    reset_n = 1'b0;
    #1;
    chk("t6_in_ready", bus.in_ready, 0);
    chk("t6_busy", bus.busy, 0);
    chk("t6_out_valid", bus.out_valid, 0);
    chk("t6_out_lane", bus.out_lane, 0);
    chk("t6_out_extra", bus.out_extra, 0);
    chk("t6_done", bus.done, 0);
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("t6_no_done", done_cnt - base, 0);
    chk("t6_no_output", got_lane.size(), nq);
    for (int i = 0; i < 5; i++) begin
      ba[i] = {$urandom, $urandom};
      bb[i] = {$urandom, $urandom};
    end
    run_burst("t6_after", 3'd0, 5, 1'b1, 1'b0);

    // Randomized bursts over all opcodes
    for (int k = 0; k < 10; k++) begin
      logic [2:0] op;
      int n;
      op = 3'($urandom_range(0, 7));
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        ba[i] = {$urandom, $urandom};
        bb[i] = {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) ba[i] = 64'hFFFFFFFF_FFFFFFFF;
        if ($urandom_range(0, 3) == 0) bb[i] = ba[i] ^ 64'h00000000_00000001;
      end
      run_burst($sformatf("rnd%0d_op%0d", k, op), op, n, 1'b1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end
endmodule
